// File: rtl/usb_sched_pkg.sv
// Shared types and helpers for the USB transaction scheduler.
package usb_sched_pkg;

   localparam int unsigned MSG_W  = 3;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned PAGE_W = 16;
   localparam int unsigned STAT_W = 16;

   localparam logic [MSG_W-1:0] NONE_MSG = 3'b000;
   localparam logic [MSG_W-1:0] IN_TOK   = 3'b001;
   localparam logic [MSG_W-1:0] OUT_TOK  = 3'b010;
   localparam logic [MSG_W-1:0] OUT_DATA = 3'b011;
   localparam logic [MSG_W-1:0] IN_DATA  = 3'b100;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACC,
      WAIT_DONE,
      RESP
   } state_e;

   typedef enum logic {
      DIR_RD,
      DIR_WR
   } dir_e;

   typedef struct packed {
      dir_e              dir;
      logic [PAGE_W-1:0] page;
      logic [DATA_W-1:0] wdata;
   } xact_t;

   // Message for a given step: address phase pair first, then the data phase pair.
   function automatic logic [MSG_W-1:0] step_msg(input dir_e dir, input logic [1:0] step);
      logic [MSG_W-1:0] m;
      unique case (step)
         2'd0:    m = OUT_TOK;
         2'd1:    m = OUT_DATA;
         2'd2:    m = (dir == DIR_WR) ? OUT_TOK : IN_TOK;
         default: m = (dir == DIR_WR) ? OUT_DATA : IN_DATA;
      endcase
      return m;
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/usb_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = read, bit 1 = write. Priority moves on advance_i.
module usb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   logic fav_wr_q, fav_wr_d;
   logic last_wr_q, last_wr_d;

   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = fav_wr_q ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

   // Remember who won; on advance favour the other requester.
   always_comb begin
      last_wr_d = (gnt_o != 2'b00) ? gnt_o[1] : last_wr_q;
      fav_wr_d  = advance_i ? ~last_wr_q : fav_wr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fav_wr_q  <= 1'b0;
         last_wr_q <= 1'b0;
      end else begin
         fav_wr_q  <= fav_wr_d;
         last_wr_q <= last_wr_d;
      end
   end

endmodule

// File: rtl/usb_xact_sched.sv
// Transaction scheduler: expands read/write requests into protocolFSM message sequences with retry.
// Optional statistics outputs enabled by defining USB_XACT_SCHED_STATS_EN.
module usb_xact_sched
   import usb_sched_pkg::*;
#(
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned WDOG_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req_i,
   input  logic [PAGE_W-1:0] rd_page_i,
   output logic              rd_done_o,
   output logic              rd_ok_o,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              wr_req_i,
   input  logic [PAGE_W-1:0] wr_page_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_done_o,
   output logic              wr_ok_o,
   output logic [MSG_W-1:0]  msg_type_o,
   output logic [DATA_W-1:0] protocol_din_o,
   input  logic              protocol_free_i,
   input  logic              timeout_i,
   input  logic [DATA_W-1:0] protocol_dout_i,
   output logic              busy_o
`ifdef USB_XACT_SCHED_STATS_EN
  ,output logic [STAT_W-1:0] stat_retries_o,
   output logic [STAT_W-1:0] stat_fails_o
`endif
);

   localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int unsigned WDOG_W  = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   state_e               state_q, state_d;
   xact_t                xact_q, xact_d;
   logic [1:0]           step_q, step_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [WDOG_W-1:0]    wdog_q, wdog_d;

   logic [MSG_W-1:0]     msg_q, msg_d;
   logic [DATA_W-1:0]    din_q, din_d;
   logic [DATA_W-1:0]    rd_data_q, rd_data_d;
   logic                 rd_done_q, rd_done_d, rd_ok_q, rd_ok_d;
   logic                 wr_done_q, wr_done_d, wr_ok_q, wr_ok_d;
   logic                 busy_q, busy_d;

   logic [1:0]           gnt;
   logic [1:0]           arb_req;
   logic                 in_wait, wdog_exp, phase_done;
   logic                 xact_ok, xact_fail, retry_take;

   assign arb_req = (state_q == IDLE) ? {wr_req_i, rd_req_i} : 2'b00;

   usb_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (arb_req),
      .advance_i (state_q == RESP),
      .gnt_o     (gnt)
   );

   // Phase outcome decode shared by next-state and output logic.
   assign in_wait    = (state_q == WAIT_ACC) || (state_q == WAIT_DONE);
   assign wdog_exp   = in_wait && (wdog_q == WDOG_LAST);
   assign phase_done = (state_q == WAIT_DONE) && protocol_free_i && !wdog_exp;
   assign xact_ok    = phase_done && !timeout_i && (step_q == 2'd3);
   assign retry_take = phase_done && timeout_i && (retry_q < RETRY_MAX);
   assign xact_fail  = wdog_exp || (phase_done && timeout_i && !(retry_q < RETRY_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         xact_q    <= '0;
         step_q    <= 2'd0;
         retry_q   <= '0;
         wdog_q    <= '0;
         msg_q     <= NONE_MSG;
         din_q     <= '0;
         rd_data_q <= '0;
         rd_done_q <= 1'b0;
         rd_ok_q   <= 1'b0;
         wr_done_q <= 1'b0;
         wr_ok_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         xact_q    <= xact_d;
         step_q    <= step_d;
         retry_q   <= retry_d;
         wdog_q    <= wdog_d;
         msg_q     <= msg_d;
         din_q     <= din_d;
         rd_data_q <= rd_data_d;
         rd_done_q <= rd_done_d;
         rd_ok_q   <= rd_ok_d;
         wr_done_q <= wr_done_d;
         wr_ok_q   <= wr_ok_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      xact_d  = xact_q;
      step_d  = step_q;
      retry_d = retry_q;
      wdog_d  = wdog_q;
      unique case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               xact_d.dir   = gnt[1] ? DIR_WR : DIR_RD;
               xact_d.page  = gnt[1] ? wr_page_i : rd_page_i;
               xact_d.wdata = wr_data_i;
               step_d       = 2'd0;
               retry_d      = '0;
               wdog_d       = '0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            wdog_d = '0;
            if (protocol_free_i) state_d = WAIT_ACC;
         end
         WAIT_ACC: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (wdog_exp)              state_d = RESP;
            else if (!protocol_free_i) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (xact_ok || xact_fail) begin
               state_d = RESP;
            end else if (retry_take) begin
               retry_d = retry_q + RETRY_W'(1);
               step_d  = step_q & 2'b10;
               state_d = ISSUE;
            end else if (phase_done) begin
               step_d  = step_q + 2'd1;
               state_d = ISSUE;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      msg_d     = NONE_MSG;
      din_d     = din_q;
      rd_data_d = rd_data_q;
      rd_done_d = 1'b0;
      rd_ok_d   = 1'b0;
      wr_done_d = 1'b0;
      wr_ok_d   = 1'b0;
      busy_d    = busy_q;
      unique case (state_q)
         IDLE: begin
            if (gnt != 2'b00) busy_d = 1'b1;
         end
         ISSUE: begin
            if (protocol_free_i) begin
               msg_d = step_msg(xact_q.dir, step_q);
               if (step_q == 2'd1)
                  din_d = DATA_W'(xact_q.page);
               else if ((step_q == 2'd3) && (xact_q.dir == DIR_WR))
                  din_d = xact_q.wdata;
            end
         end
         WAIT_DONE: begin
            if (xact_ok && (xact_q.dir == DIR_RD)) rd_data_d = protocol_dout_i;
         end
         RESP:    busy_d = 1'b0;
         default: ;
      endcase
      // Done pulse lands in the RESP cycle.
      if (xact_ok || xact_fail) begin
         rd_done_d = (xact_q.dir == DIR_RD);
         rd_ok_d   = (xact_q.dir == DIR_RD) && xact_ok;
         wr_done_d = (xact_q.dir == DIR_WR);
         wr_ok_d   = (xact_q.dir == DIR_WR) && xact_ok;
      end
   end

   assign msg_type_o     = msg_q;
   assign protocol_din_o = din_q;
   assign rd_data_o      = rd_data_q;
   assign rd_done_o      = rd_done_q;
   assign rd_ok_o        = rd_ok_q;
   assign wr_done_o      = wr_done_q;
   assign wr_ok_o        = wr_ok_q;
   assign busy_o         = busy_q;

`ifdef USB_XACT_SCHED_STATS_EN
   logic [STAT_W-1:0] stat_retries_q, stat_fails_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_retries_q <= '0;
         stat_fails_q   <= '0;
      end else begin
         if (retry_take) stat_retries_q <= sat_inc(stat_retries_q);
         if (xact_fail)  stat_fails_q   <= sat_inc(stat_fails_q);
      end
   end

   assign stat_retries_o = stat_retries_q;
   assign stat_fails_o   = stat_fails_q;
`endif

endmodule
